jk_excitation_driver: RTL and testbench

- Drives the J/K inputs of a W-bit JK flip-flop bank so the bank's state reaches requested target words.
- Targets arrive through a valid/ready stream and are buffered in an internal FIFO.
- For each target, the block computes the JK excitation from the bank's current q, applies it for one cycle, checks q, and retries or flags an error.
- Sits between a control/sequencer stage and the flip-flop bank.

---
 rtl/jk_excitation_driver.sv | 142 ++++++++++++++
 tb/tb_jk_excitation_driver.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// JK flip-flop bank excitation driver: buffers target words and drives J/K until q matches.
// Optional JK_TOGGLE_PREF_EN: changing bits are driven as toggles (j=k=1) instead of set/reset.
module jk_excitation_driver #(
    parameter int W         = 5,
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [W-1:0] q_fb,
    output logic [W-1:0] j,
    output logic [W-1:0] k,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [W-1:0]   tgt_r;
    logic [RW-1:0]  retry_cnt;

    logic           push;
    logic           pop;
    logic [W-1:0]   sel_tgt;
    logic [W-1:0]   ex_j;
    logic [W-1:0]   ex_k;

    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (count != '0);
    assign busy     = (state != IDLE);

    // In IDLE the excitation is built from the word about to be popped, otherwise from the held target.
    always_comb begin
        sel_tgt = (state == IDLE) ? mem[rd_ptr] : tgt_r;
`ifdef JK_TOGGLE_PREF_EN
        ex_j = q_fb ^ sel_tgt;
        ex_k = q_fb ^ sel_tgt;
`else
        ex_j = sel_tgt & ~q_fb;
        ex_k = q_fb & ~sel_tgt;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Drive for one cycle, check on the next, and re-drive from the fresh q until the retry budget runs out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            j         <= '0;
            k         <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            tgt_r     <= '0;
            retry_cnt <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tgt_r     <= mem[rd_ptr];
                        j         <= ex_j;
                        k         <= ex_k;
                        retry_cnt <= '0;
                        state     <= DRIVE;
                    end else begin
                        j <= '0;
                        k <= '0;
                    end
                end
                DRIVE: begin
                    j     <= '0;
                    k     <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (q_fb == tgt_r) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (retry_cnt < RW'(MAX_RETRY)) begin
                        retry_cnt <= retry_cnt + RW'(1);
                        j         <= ex_j;
                        k         <= ex_k;
                        state     <= DRIVE;
                    end else begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    j     <= '0;
                    k     <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench for jk_excitation_driver with an ideal (or stuck-at-zero) JK bank model.
module tb_jk_excitation_driver;

    localparam int W         = 5;
    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 2;

    typedef struct {
        logic [W-1:0] tgt;
        bit           is_err;
        int           drives;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] q_fb;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         busy;
    logic         done;
    logic         err;

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;

    logic [W-1:0] bank_q = '0;
    bit           stuck = 1'b0;
    logic [W-1:0] model_q = '0;

    exp_t         sb[$];
    exp_t         e_mon;
    int           drive_seen = 0;
    logic [W-1:0] last_j = '0;
    logic [W-1:0] last_k = '0;
    logic [W-1:0] ej;
    logic [W-1:0] ek;
    int           last_done_cyc = -1;
    bit           prev_pulse = 1'b0;
    int           last_push_cyc = 0;

    jk_excitation_driver #(
        .W(W),
        .DEPTH(DEPTH),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .q_fb(q_fb),
        .j(j),
        .k(k),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ideal JK bank; when stuck, q reads as zero and the bank holds its value.
    assign q_fb = stuck ? '0 : bank_q;
    always @(posedge clk) begin
        if (!stuck) bank_q <= (j & ~bank_q) | (~k & bank_q);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-bit excitation table of a JK flip-flop with the chosen don't-care resolution.
    function automatic void refExcite(input logic [W-1:0] q, input logic [W-1:0] t,
                                      output logic [W-1:0] rj, output logic [W-1:0] rk);
        rj = '0;
        rk = '0;
        for (int i = 0; i < W; i++) begin
            case ({q[i], t[i]})
`ifdef JK_TOGGLE_PREF_EN
                2'b01:   begin rj[i] = 1'b1; rk[i] = 1'b1; end
                2'b10:   begin rj[i] = 1'b1; rk[i] = 1'b1; end
`else
                2'b01:   begin rj[i] = 1'b1; rk[i] = 1'b0; end
                2'b10:   begin rj[i] = 1'b0; rk[i] = 1'b1; end
`endif
                default: begin rj[i] = 1'b0; rk[i] = 1'b0; end
            endcase
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            drive_seen = 0;
            prev_pulse = 1'b0;
        end else begin
            if ((j | k) != '0) begin
                if (sb.size() == 0) begin
                    checkOutput("drive_without_target", 1, 0);
                end else begin
                    refExcite(q_fb, sb[0].tgt, ej, ek);
                    checkOutput("j_vector", j, ej);
                    checkOutput("k_vector", k, ek);
                end
                checkOutput("busy_in_drive", busy, 1);
                drive_seen++;
                last_j = j;
                last_k = k;
            end
            if (done || err) begin
                checkOutput("done_err_exclusive", done && err, 0);
                checkOutput("pulse_width", prev_pulse, 0);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pulse", 1, 0);
                end else begin
                    e_mon = sb.pop_front();
                    checkOutput("outcome_err", err, e_mon.is_err);
                    checkOutput("drive_count", drive_seen, e_mon.drives);
                    if (done) checkOutput("q_at_done", q_fb, e_mon.tgt);
                end
                drive_seen = 0;
                if (done) last_done_cyc = cyc;
            end
            prev_pulse = done || err;
        end
    end

    task automatic applyStimulus(input logic [W-1:0] w, output int stalls);
        bit   pushed;
        exp_t e_new;
        pushed = 1'b0;
        stalls = 0;
        for (int n = 0; n < 500 && !pushed; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = w;
            if (in_ready) begin
                @(posedge clk);
                last_push_cyc = cyc;
                e_new.tgt = w;
                if (stuck) begin
                    e_new.is_err = (w != '0);
                    e_new.drives = (w != '0) ? MAX_RETRY + 1 : 0;
                end else begin
                    e_new.is_err = 1'b0;
                    e_new.drives = (w != model_q) ? 1 : 0;
                    model_q      = w;
                end
                sb.push_back(e_new);
                pushed = 1'b1;
            end else begin
                stalls++;
            end
        end
        if (!pushed) checkOutput("push_timeout", 0, 1);
    endtask

    task automatic releaseValid();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 2000 && !idle; n++) begin
            @(negedge clk);
            #1;
            if (!busy && sb.size() == 0) idle = 1'b1;
        end
        if (!idle) checkOutput("idle_timeout", 0, 1);
    endtask

    task automatic setStuck(input bit s);
        if (stuck && !s) model_q = bank_q;
        stuck = s;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int st;
        int stall_total;
        logic [W-1:0] w;

        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 5'b11111;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checkOutput("reset_j", j, 0);
            checkOutput("reset_k", k, 0);
            checkOutput("reset_busy", busy, 0);
            checkOutput("reset_in_ready", in_ready, 1);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("no_push_in_reset_busy", busy, 0);
        checkOutput("no_push_in_reset_ready", in_ready, 1);

        // 00000 -> 10110, with the push-to-done latency measured
        applyStimulus(5'b10110, st);
        releaseValid();
        waitIdle();
        checkOutput("first_j", last_j, 5'b10110);
        checkOutput("first_k", last_k, 5'b00000);
        checkOutput("done_latency", last_done_cyc, last_push_cyc + 4);
        checkOutput("bank_reached_10110", q_fb, 5'b10110);

        applyStimulus(5'b01101, st);
        releaseValid();
        waitIdle();
`ifdef JK_TOGGLE_PREF_EN
        checkOutput("second_j", last_j, 5'b11011);
        checkOutput("second_k", last_k, 5'b11011);
`else
        checkOutput("second_j", last_j, 5'b01001);
        checkOutput("second_k", last_k, 5'b10010);
`endif
        checkOutput("bank_reached_01101", q_fb, 5'b01101);

        applyStimulus(5'b00000, st);
        releaseValid();
        waitIdle();
        checkOutput("bank_cleared", q_fb, 5'b00000);

        // Stuck bank: retries exhaust and err is reported
        setStuck(1'b1);
        applyStimulus(5'b00001, st);
        releaseValid();
        waitIdle();
        checkOutput("stuck_j", last_j, 5'b00001);

        stall_total = 0;
        for (int n = 0; n < 6; n++) begin
            w = W'($urandom_range(1, 31));
            applyStimulus(w, st);
            stall_total += st;
        end
        releaseValid();
        waitIdle();
        checkOutput("in_ready_backpressure", stall_total > 0, 1);

        // Reset during a retry DRIVE with two words queued
        applyStimulus(5'b00001, st);
        applyStimulus(5'b00010, st);
        applyStimulus(5'b00100, st);
        releaseValid();
        @(negedge clk);
        checkOutput("drive_before_reset", j, 5'b00001);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("async_reset_j", j, 0);
        checkOutput("async_reset_k", k, 0);
        checkOutput("async_reset_busy", busy, 0);
        checkOutput("async_reset_ready", in_ready, 1);
        checkOutput("async_reset_pulses", {done, err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        setStuck(1'b0);
        @(negedge clk);
        checkOutput("fifo_flushed", busy, 0);
        applyStimulus(5'b00011, st);
        releaseValid();
        waitIdle();
        checkOutput("after_reset_target", q_fb, 5'b00011);

        for (int b = 0; b < 6; b++) begin
            setStuck($urandom_range(0, 3) == 0);
            for (int n = 0; n < 6; n++) begin
                applyStimulus(W'($urandom), st);
                if ($urandom_range(0, 2) != 0) begin
                    releaseValid();
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            releaseValid();
            waitIdle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
